id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Parametrised RV32I/RV32E decode stage between IF/ID and ID/EX.
- Decodes the instruction and reads an internal register file, with write-back bypass and x0 hard-wired to zero.
- Detects load-use hazards and stalls.
- Drives a valid/ready-handshaked ID/EX pipeline register with flush support and illegal-instruction flagging.

Parameters:
XLEN, 32, datapath width of pc, imm, rv1, rv2, wb_data (32 or 64; imm sign-extends to XLEN)
NREG, 32, architectural register count (32 = RV32I, 16 = RV32E)
OPW, 6, width of internal opcode field

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc  in  XLEN  pc of instruction
id_ready  out  1  ID accepts if_* this cycle
wb_we  in  1  register write enable
wb_rd  in  5  write register index
wb_data  in  XLEN  write data
flush  in  1  kill ID/EX contents (branch redirect)
ex_ready  in  1  EX accepts ID/EX contents
ex_valid  out  1  ID/EX valid
ex_pc  out  XLEN  registered pc
ex_imm  out  XLEN  decoded immediate
ex_op  out  OPW  internal opcode
ex_rs1, ex_rs2, ex_rd  out  5 each  register indices
ex_rv1, ex_rv2  out  XLEN  operand values
ex_illegal  out  1  instruction was undecodable

Behaviour:
- Reset (rst_n=0 at edge):
  - All ex_* outputs go to 0.
  - All NREG registers clear to 0.
  - Reset wins over every other input.
- Opcode map:
  - LUI 0, AUIPC 1, JAL 2, JALR 3, BEQ..BGEU 4-9, LB/LH/LW/LBU/LHU 10-14, SB/SH/SW 15-17.
  - ADDI 18, SLTI 19, SLTIU 20, XORI 21, ORI 22, ANDI 23, SLLI 24, SRLI 25, SRAI 26.
  - ADD 27, SUB 28, SLL 29, SLT 30, SLTU 31, XOR 32, SRL 33, SRA 34, OR 35, AND 36.
  - OP-IMM shifts decode under 0010011 by funct3 001/101 and funct7.
- Immediates:
  - I/S/B/U/J formats, sign-extended to XLEN.
  - SLTIU/XORI/ORI/ANDI zero-extend imm[11:0].
  - Shift immediates take shamt = instr[24:20], zero-extended.
  - R-type imm = 0.
- Illegal instructions:
  - Covers unknown major opcode, unlisted funct3/funct7, JALR with funct3≠0, and any used rs1/rs2/rd index ≥ NREG.
  - Result: ex_op = all-ones, ex_illegal = 1, ex_valid still asserted so EX can trap.
- Register read:
  - Index 0 reads 0.
  - If wb_we && wb_rd==rsX && wb_rd≠0, the read returns wb_data (same-cycle bypass).
  - Writes to x0 are ignored; writes with wb_rd ≥ NREG are ignored.
- Load-use hazard:
  - hazard = ex_valid && ex_op∈{10..14} && ex_rd≠0 && (ex_rd==rs1 or ex_rd==rs2).
  - A source counts only if the format uses it: rs1 unused by LUI/AUIPC/JAL; rs2 used only by branch/store/R-type.
- Handshake:
  - adv = !ex_valid || ex_ready.
  - id_ready = adv && !hazard.
  - On an edge with adv: ID/EX loads the decoded fields and ex_valid <= if_valid && !hazard; a hazard inserts a bubble with ex_valid=0.
  - When !adv, ID/EX holds every field unchanged.
  - if_* is consumed only when if_valid && id_ready.
- Flush: ex_valid <= 0 on that edge, regardless of adv/hazard; id_ready is forced to 0 that cycle.
- Latency:
  - One cycle from accepted if_* to ex_valid.
  - Load-use adds exactly one bubble cycle.
- Outputs change only on the clock edge; id_ready is combinational.

Test Plan:
- Reset: hold rst_n=0 two cycles with if_valid=1 -> ex_valid=0, ex_op=0, all regs read 0 afterwards.
- Decode: if_instr=0x00500093 (ADDI x1,x0,5), pc=0x100 -> next cycle ex_op=18, ex_imm=5, ex_rd=1, ex_rv1=0, ex_pc=0x100, ex_illegal=0.
- Bypass: wb_we=1, wb_rd=2, wb_data=0xDEADBEEF while if_instr=0x002081B3 (ADD x3,x1,x2) -> ex_op=27, ex_rv2=0xDEADBEEF.
- Load-use: LW x5,0(x1) accepted, then ADD x6,x5,x0 presented -> id_ready=0 one cycle, bubble (ex_valid=0), ADD issued next cycle.
- Backpressure: ex_ready=0 for 3 cycles with if_valid=1 -> id_ready=0, ex_* held constant; release -> next instruction loads.
- Flush: flush=1 with a valid ID/EX entry -> ex_valid=0 next cycle.
- RV32E: NREG=16, if_instr=ADDI x17,x0,1 -> ex_illegal=1, ex_op=6'h3F.
- SRAI: if_instr=0x4030D093 -> ex_op=26, ex_imm=3.

Source files
------------

// File: rtl/id_stage_pipe.sv
// RV32I/RV32E decode stage: instruction decode, register file read with write-back
// bypass, load-use stall and a valid/ready ID/EX pipeline register with flush.
module id_stage_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned OPW  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [OPW-1:0]  ex_op,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rv1,
  output logic [XLEN-1:0] ex_rv2,
  output logic            ex_illegal
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_f;
  logic [4:0]      rs1_f;
  logic [4:0]      rs2_f;
  logic [XLEN-1:0] imm_i, imm_iz, imm_sh, imm_s, imm_b, imm_u, imm_j;

  assign opc   = if_instr[6:0];
  assign rd_f  = if_instr[11:7];
  assign f3    = if_instr[14:12];
  assign rs1_f = if_instr[19:15];
  assign rs2_f = if_instr[24:20];
  assign f7    = if_instr[31:25];

  assign imm_i  = XLEN'($signed(if_instr[31:20]));
  assign imm_iz = XLEN'(if_instr[31:20]);
  assign imm_sh = XLEN'(if_instr[24:20]);
  assign imm_s  = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
  assign imm_b  = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                 if_instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({if_instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                 if_instr[30:21], 1'b0}));

  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_legal;
  logic            dec_ill;
  logic            use_rs1, use_rs2, use_rd;
  logic            idx_bad;

  // Opcode/immediate decode plus which register fields the format actually uses
  always_comb begin
    dec_op    = '0;
    dec_imm   = '0;
    dec_legal = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    case (opc)
      7'b0110111: begin dec_op = OPW'(0); dec_imm = imm_u; use_rd = 1'b1; end
      7'b0010111: begin dec_op = OPW'(1); dec_imm = imm_u; use_rd = 1'b1; end
      7'b1101111: begin dec_op = OPW'(2); dec_imm = imm_j; use_rd = 1'b1; end
      7'b1100111: begin
        dec_op    = OPW'(3);
        dec_imm   = imm_i;
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        dec_legal = (f3 == 3'b000);
      end
      7'b1100011: begin
        dec_imm = imm_b;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec_op = OPW'(4);
          3'b001:  dec_op = OPW'(5);
          3'b100:  dec_op = OPW'(6);
          3'b101:  dec_op = OPW'(7);
          3'b110:  dec_op = OPW'(8);
          3'b111:  dec_op = OPW'(9);
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        case (f3)
          3'b000:  dec_op = OPW'(10);
          3'b001:  dec_op = OPW'(11);
          3'b010:  dec_op = OPW'(12);
          3'b100:  dec_op = OPW'(13);
          3'b101:  dec_op = OPW'(14);
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        dec_imm = imm_s;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec_op = OPW'(15);
          3'b001:  dec_op = OPW'(16);
          3'b010:  dec_op = OPW'(17);
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec_imm = imm_i;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        case (f3)
          3'b000: dec_op = OPW'(18);
          3'b010: dec_op = OPW'(19);
          3'b011: begin dec_op = OPW'(20); dec_imm = imm_iz; end
          3'b100: begin dec_op = OPW'(21); dec_imm = imm_iz; end
          3'b110: begin dec_op = OPW'(22); dec_imm = imm_iz; end
          3'b111: begin dec_op = OPW'(23); dec_imm = imm_iz; end
          3'b001: begin
            dec_op    = OPW'(24);
            dec_imm   = imm_sh;
            dec_legal = (f7 == 7'b0000000);
          end
          default: begin
            dec_imm = imm_sh;
            if (f7 == 7'b0000000)      dec_op = OPW'(25);
            else if (f7 == 7'b0100000) dec_op = OPW'(26);
            else                       dec_legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_op = OPW'(27);
            3'b001:  dec_op = OPW'(29);
            3'b010:  dec_op = OPW'(30);
            3'b011:  dec_op = OPW'(31);
            3'b100:  dec_op = OPW'(32);
            3'b101:  dec_op = OPW'(33);
            3'b110:  dec_op = OPW'(35);
            default: dec_op = OPW'(36);
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  dec_op = OPW'(28);
            3'b101:  dec_op = OPW'(34);
            default: dec_legal = 1'b0;
          endcase
        end else begin
          dec_legal = 1'b0;
        end
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign idx_bad = (use_rs1 && (32'(rs1_f) >= NREG)) ||
                   (use_rs2 && (32'(rs2_f) >= NREG)) ||
                   (use_rd  && (32'(rd_f)  >= NREG));
  assign dec_ill = !dec_legal || idx_bad;

  // Register file; x0 and out-of-range indices are never written
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic            wb_wr_en;
  logic [XLEN-1:0] rv1_c, rv2_c;

  assign wb_wr_en = wb_we && (wb_rd != 5'd0) && (32'(wb_rd) < NREG);

  always_comb begin
    rf_d = rf_q;
    if (wb_wr_en) rf_d[wb_rd[IW-1:0]] = wb_data;
  end

  always_comb begin
    rv1_c = '0;
    if (rs1_f != 5'd0) begin
      if (wb_wr_en && (wb_rd == rs1_f))  rv1_c = wb_data;
      else if (32'(rs1_f) < NREG)         rv1_c = rf_q[rs1_f[IW-1:0]];
    end
  end

  always_comb begin
    rv2_c = '0;
    if (rs2_f != 5'd0) begin
      if (wb_wr_en && (wb_rd == rs2_f))  rv2_c = wb_data;
      else if (32'(rs2_f) < NREG)         rv2_c = rf_q[rs2_f[IW-1:0]];
    end
  end

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [OPW-1:0]  ex_op_q, ex_op_d;
  logic [4:0]      ex_rs1_q, ex_rs1_d;
  logic [4:0]      ex_rs2_q, ex_rs2_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [XLEN-1:0] ex_rv1_q, ex_rv1_d;
  logic [XLEN-1:0] ex_rv2_q, ex_rv2_d;
  logic            ex_illegal_q, ex_illegal_d;
  logic            adv, hazard, ex_is_load;

  // A load in ID/EX cannot forward its result, so a consumer behind it waits one cycle
  assign ex_is_load = (ex_op_q >= OPW'(10)) && (ex_op_q <= OPW'(14));
  assign hazard     = ex_valid_q && ex_is_load && (ex_rd_q != 5'd0) &&
                      ((use_rs1 && (ex_rd_q == rs1_f)) ||
                       (use_rs2 && (ex_rd_q == rs2_f)));
  assign adv        = !ex_valid_q || ex_ready;
  assign id_ready   = adv && !hazard && !flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_imm_d     = ex_imm_q;
    ex_op_d      = ex_op_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_rd_d      = ex_rd_q;
    ex_rv1_d     = ex_rv1_q;
    ex_rv2_d     = ex_rv2_q;
    ex_illegal_d = ex_illegal_q;
    if (adv) begin
      ex_valid_d   = if_valid && !hazard;
      ex_pc_d      = if_pc;
      ex_imm_d     = dec_imm;
      ex_op_d      = dec_ill ? '1 : dec_op;
      ex_rs1_d     = rs1_f;
      ex_rs2_d     = rs2_f;
      ex_rd_d      = rd_f;
      ex_rv1_d     = rv1_c;
      ex_rv2_d     = rv2_c;
      ex_illegal_d = dec_ill;
    end
    if (flush) ex_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q         <= '{default: '0};
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_imm_q     <= '0;
      ex_op_q      <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_rd_q      <= '0;
      ex_rv1_q     <= '0;
      ex_rv2_q     <= '0;
      ex_illegal_q <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_imm_q     <= ex_imm_d;
      ex_op_q      <= ex_op_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_rd_q      <= ex_rd_d;
      ex_rv1_q     <= ex_rv1_d;
      ex_rv2_q     <= ex_rv2_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm     = ex_imm_q;
  assign ex_op      = ex_op_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rv1     = ex_rv1_q;
  assign ex_rv2     = ex_rv2_q;
  assign ex_illegal = ex_illegal_q;

endmodule
